// File: rtl/spike_count_if.sv
// Handshake and result bundle between the classifier and its requester.
// master drives start/spike_in; slave (the classifier) drives the results.
interface spike_count_if #(
  parameter int num_neurons = 4,
  parameter int index_width = 2,
  parameter int count_width = 8
);
  logic                   start;
  logic [num_neurons-1:0] spike_in;
  logic                   busy;
  logic                   result_valid;
  logic [index_width-1:0] winner;
  logic [count_width-1:0] winner_count;
  logic                   no_spike;

  modport master (
    output start, spike_in,
    input  busy, result_valid, winner, winner_count, no_spike
  );

  modport slave (
    input  start, spike_in,
    output busy, result_valid, winner, winner_count, no_spike
  );
endinterface

// File: rtl/spike_count_classifier.sv
// Counts per-neuron spikes over a fixed window, then scans for the most active neuron.
// Macro SPIKE_COUNT_SATURATE_EN: counters saturate instead of wrapping.
module spike_count_classifier #(
  parameter int num_neurons   = 4,
  parameter int index_width   = 2,
  parameter int count_width   = 8,
  parameter int window_cycles = 100
) (
  input logic           i_clk,
  input logic           i_rst,
  spike_count_if.slave  io_bus
);

  localparam int WIN_W = (window_cycles > 1) ? $clog2(window_cycles) : 1;
  localparam logic [WIN_W-1:0]       WIN_LAST = WIN_W'(window_cycles - 1);
  localparam logic [index_width-1:0] IDX_LAST = index_width'(num_neurons - 1);
  localparam logic [index_width-1:0] IDX_ZERO = {index_width{1'b0}};
  localparam logic [count_width-1:0] CNT_ZERO = {count_width{1'b0}};
  localparam logic [count_width-1:0] CNT_MAX  = {count_width{1'b1}};

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_COUNT = 2'd1,
    S_SCAN  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t                 r_state;
  state_t                 w_next;
  logic [count_width-1:0] r_cnt [num_neurons];
  logic [WIN_W-1:0]       r_win;
  logic [index_width-1:0] r_idx;
  logic [index_width-1:0] r_best_idx;
  logic [count_width-1:0] r_best_cnt;
  logic [index_width-1:0] w_best_idx;
  logic [count_width-1:0] w_best_cnt;
  logic [count_width-1:0] w_scan_cnt;
  logic                   r_busy;
  logic                   r_valid;
  logic [index_width-1:0] r_winner;
  logic [count_width-1:0] r_winner_count;
  logic                   r_no_spike;

  function automatic logic [count_width-1:0] bump(input logic [count_width-1:0] c);
`ifdef SPIKE_COUNT_SATURATE_EN
    if (c == CNT_MAX) begin
      bump = c;
    end else begin
      bump = c + count_width'(1);
    end
`else
    bump = c + count_width'(1);
`endif
  endfunction

  // State register.
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (io_bus.start) w_next = S_COUNT;
        else              w_next = S_IDLE;
      end
      S_COUNT: begin
        if (r_win == WIN_LAST) w_next = S_SCAN;
        else                   w_next = S_COUNT;
      end
      S_SCAN: begin
        if (r_idx == IDX_LAST) w_next = S_DONE;
        else                   w_next = S_SCAN;
      end
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Running best: index 0 seeds it, later indices must be strictly greater.
  always_comb begin
    w_scan_cnt = r_cnt[r_idx];
    w_best_idx = r_best_idx;
    w_best_cnt = r_best_cnt;
    if ((r_idx == IDX_ZERO) || (w_scan_cnt > r_best_cnt)) begin
      w_best_idx = r_idx;
      w_best_cnt = w_scan_cnt;
    end else begin
      w_best_idx = r_best_idx;
      w_best_cnt = r_best_cnt;
    end
  end

  // Counters, window timer and scan pointer.
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      for (int i = 0; i < num_neurons; i++) r_cnt[i] <= CNT_ZERO;
      r_win      <= {WIN_W{1'b0}};
      r_idx      <= IDX_ZERO;
      r_best_idx <= IDX_ZERO;
      r_best_cnt <= CNT_ZERO;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (io_bus.start) begin
            for (int i = 0; i < num_neurons; i++) r_cnt[i] <= CNT_ZERO;
            r_win <= {WIN_W{1'b0}};
            r_idx <= IDX_ZERO;
          end
        end
        S_COUNT: begin
          for (int i = 0; i < num_neurons; i++) begin
            if (io_bus.spike_in[i]) r_cnt[i] <= bump(r_cnt[i]);
          end
          r_win <= r_win + WIN_W'(1);
        end
        S_SCAN: begin
          r_idx      <= r_idx + index_width'(1);
          r_best_idx <= w_best_idx;
          r_best_cnt <= w_best_cnt;
        end
        default: begin
          r_idx <= IDX_ZERO;
        end
      endcase
    end
  end

  // Registered outputs; results captured on the last scan step so they appear in DONE.
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_busy         <= 1'b0;
      r_valid        <= 1'b0;
      r_winner       <= IDX_ZERO;
      r_winner_count <= CNT_ZERO;
      r_no_spike     <= 1'b0;
    end else begin
      r_busy  <= (w_next == S_COUNT) || (w_next == S_SCAN);
      r_valid <= (w_next == S_DONE);
      if ((r_state == S_SCAN) && (w_next == S_DONE)) begin
        r_winner       <= w_best_idx;
        r_winner_count <= w_best_cnt;
        r_no_spike     <= (w_best_cnt == CNT_ZERO);
      end
    end
  end

  assign io_bus.busy         = r_busy;
  assign io_bus.result_valid = r_valid;
  assign io_bus.winner       = r_winner;
  assign io_bus.winner_count = r_winner_count;
  assign io_bus.no_spike     = r_no_spike;

endmodule

// File: tb/tb_spike_count_classifier.sv
// Scoreboard bench: two classifiers (4-bit and 3-bit counters) share stimulus;
// expected results come from a popcount-based reference model.
module tb_spike_count_classifier;
  localparam int N    = 4;
  localparam int IW   = 2;
  localparam int W    = 10;
  localparam int CW_A = 4;
  localparam int CW_B = 3;

  typedef struct {
    int win;
    int cnt;
    int nos;
    int cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;
  exp_t q_a[$];
  exp_t q_b[$];
  logic [N-1:0] spk [W];
  int   dens [N];

  spike_count_if #(.num_neurons(N), .index_width(IW), .count_width(CW_A)) bus_a ();
  spike_count_if #(.num_neurons(N), .index_width(IW), .count_width(CW_B)) bus_b ();

  spike_count_classifier #(.num_neurons(N), .index_width(IW), .count_width(CW_A),
                           .window_cycles(W)) dut_a (.i_clk(clk), .i_rst(rst), .io_bus(bus_a));
  spike_count_classifier #(.num_neurons(N), .index_width(IW), .count_width(CW_B),
                           .window_cycles(W)) dut_b (.i_clk(clk), .i_rst(rst), .io_bus(bus_b));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic drive(input logic s, input logic [N-1:0] sp);
    bus_a.start = s;    bus_b.start = s;
    bus_a.spike_in = sp; bus_b.spike_in = sp;
  endtask

  // Reference: total spikes per neuron, then wrap or clamp, then first strict maximum.
  function automatic exp_t model(input int cw, input int c0);
    exp_t e;
    int   lim = 1 << cw;
    int   tot;
    int   c;
    e.win = 0;
    e.cnt = -1;
    for (int i = 0; i < N; i++) begin
      tot = 0;
      for (int j = 0; j < W; j++) tot += int'(spk[j][i]);
`ifdef SPIKE_COUNT_SATURATE_EN
      c = (tot > lim - 1) ? lim - 1 : tot;
`else
      c = tot % lim;
`endif
      if (c > e.cnt) begin
        e.cnt = c;
        e.win = i;
      end
    end
    e.nos = (e.cnt == 0) ? 1 : 0;
    e.cyc = c0 + W + N;
    return e;
  endfunction

  task automatic chk_zero(input string tag);
    chk({tag, "_busy_a"},  int'(bus_a.busy), 0);
    chk({tag, "_valid_a"}, int'(bus_a.result_valid), 0);
    chk({tag, "_win_a"},   int'(bus_a.winner), 0);
    chk({tag, "_cnt_a"},   int'(bus_a.winner_count), 0);
    chk({tag, "_nos_a"},   int'(bus_a.no_spike), 0);
    chk({tag, "_busy_b"},  int'(bus_b.busy), 0);
    chk({tag, "_cnt_b"},   int'(bus_b.winner_count), 0);
  endtask

  task automatic rand_window();
    for (int i = 0; i < N; i++) dens[i] = $urandom_range(0, 100);
    for (int j = 0; j < W; j++)
      for (int i = 0; i < N; i++) spk[j][i] = ($urandom_range(0, 99) < dens[i]);
  endtask

  // One classification; with do_rst the window is cut by a one-cycle reset.
  task automatic run_txn(input bit do_rst);
    int c0;
    @(negedge clk);
    drive(1'b1, N'($urandom_range(0, 15)));
    c0 = cyc + 1;
    if (!do_rst) begin
      q_a.push_back(model(CW_A, c0));
      q_b.push_back(model(CW_B, c0));
    end
    for (int j = 0; j < W; j++) begin
      @(negedge clk);
      if (j == 0) chk("busy_in_count", int'(bus_a.busy), 1);
      if (do_rst && j == 4) begin
        rst = 1'b0;
        drive(1'b1, spk[j]);
        @(negedge clk);
        rst = 1'b1;
        drive(1'b0, 4'b0000);
        chk_zero("after_rst");
        return;
      end
      drive(1'($urandom_range(0, 1)), spk[j]);
    end
    for (int j = 0; j <= N; j++) begin
      @(negedge clk);
      if (j == N - 1) chk("busy_in_scan", int'(bus_a.busy), 1);
      if (j == N)     chk("busy_in_done", int'(bus_a.busy), 0);
      drive(1'($urandom_range(0, 1)), N'($urandom_range(0, 15)));
    end
  endtask

  task automatic idle_gap(input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      drive(1'b0, N'($urandom_range(0, 15)));
    end
  endtask

  // Monitors: every result_valid pulse must match the oldest expected result.
  always @(negedge clk) begin
    if (bus_a.result_valid === 1'b1) begin
      if (q_a.size() == 0) begin
        chk("a_unexpected_valid", 1, 0);
      end else begin
        exp_t e;
        e = q_a.pop_front();
        chk("a_winner",  int'(bus_a.winner), e.win);
        chk("a_count",   int'(bus_a.winner_count), e.cnt);
        chk("a_nospike", int'(bus_a.no_spike), e.nos);
        chk("a_latency", cyc, e.cyc);
      end
    end
  end

  always @(negedge clk) begin
    if (bus_b.result_valid === 1'b1) begin
      if (q_b.size() == 0) begin
        chk("b_unexpected_valid", 1, 0);
      end else begin
        exp_t e;
        e = q_b.pop_front();
        chk("b_winner",  int'(bus_b.winner), e.win);
        chk("b_count",   int'(bus_b.winner_count), e.cnt);
        chk("b_nospike", int'(bus_b.no_spike), e.nos);
        chk("b_latency", cyc, e.cyc);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    drive(1'b1, 4'b1111);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_zero("reset");
    rst = 1'b1;
    drive(1'b0, 4'b0000);
    idle_gap(2);

    for (int j = 0; j < W; j++) spk[j] = 4'b0100;
    run_txn(1'b0);
    for (int j = 0; j < W; j++) spk[j] = {(j >= 5), (j < 5), 1'b0, (j < 2)};
    run_txn(1'b0);
    for (int j = 0; j < W; j++) spk[j] = 4'b0000;
    idle_gap(1);
    run_txn(1'b0);
    for (int j = 0; j < W; j++) spk[j] = {2'b00, (j < 5), 1'b1};
    run_txn(1'b0);

    for (int t = 0; t < 25; t++) begin
      rand_window();
      idle_gap($urandom_range(0, 2));
      run_txn(1'b0);
    end

    rand_window();
    run_txn(1'b1);
    idle_gap(W + N + 3);
    chk("no_result_after_rst", q_a.size(), 0);

    for (int t = 0; t < 15; t++) begin
      rand_window();
      idle_gap($urandom_range(0, 2));
      run_txn(1'b0);
    end

    idle_gap(4);
    chk("queue_a_drained", q_a.size(), 0);
    chk("queue_b_drained", q_b.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/spike_count_classifier.md
# spike_count_classifier

Downstream readout stage for the integrate-and-fire neuron layer. It counts the output spikes of `num_neurons` neurons over a fixed window of `window_cycles` clock cycles. It then scans the counts sequentially and reports the index and count of the most active neuron as the network's classification result. One result is produced per `start` request, with a single-cycle `result_valid` pulse.

## Interface
Parameters:
- `num_neurons`, 4: number of spike inputs and per-neuron counters.
- `index_width`, 2: width of `winner`; must satisfy 2^`index_width` >= `num_neurons`.
- `count_width`, 8: width of each spike counter and of `winner_count`.
- `window_cycles`, 100: length of the counting window in clock cycles (>= 1).

Ports:
- `clk` input 1: single clock; all logic is rising-edge.
- `rst` input 1: synchronous, active-low reset (0 = reset).
- `start` input 1: begin a classification; sampled only in IDLE.
- `spike_in` input `num_neurons`: one spike bit per neuron, e.g. the `spike_out` of each neuron.
- `busy` output 1: high in COUNT and SCAN.
- `result_valid` output 1: one-cycle pulse in DONE.
- `winner` output `index_width`: index of the highest-count neuron.
- `winner_count` output `count_width`: spike count of `winner`.
- `no_spike` output 1: all counts were zero in the last window.

## Operation
- The FSM has four states: IDLE, COUNT, SCAN and DONE.
- IDLE:
  - `start`=1 → COUNT.
  - On entry to COUNT, all per-neuron counters and the window counter clear to 0.
- COUNT:
  - On each rising edge, counter[i] increments by 1 for every bit i where `spike_in[i]`=1.
  - The state lasts exactly `window_cycles` edges, then → SCAN.
- SCAN:
  - Scans one counter per cycle, index 0 up to `num_neurons`-1, keeping a running best index and count.
  - Index 0 initialises the best; a later index replaces it only if its count is strictly greater. Ties therefore resolve to the lowest index.
  - After the last index → DONE.
- DONE:
  - `result_valid`=1 for one cycle.
  - `winner`, `winner_count` and `no_spike` (set when best count == 0) are registered.
  - Then → IDLE.
- Result outputs hold their value until the next DONE, or until reset.
- `start` is ignored in COUNT, SCAN and DONE; there is no queuing.
- `spike_in` is ignored outside COUNT.
- Counter overflow behaviour is set by the configuration macro.
- Reset (`rst`=0) in any state:
  - On the next edge: state IDLE, and all counters, `busy`, `result_valid`, `winner`, `winner_count` and `no_spike` go to 0.
  - A window interrupted by reset produces no result.

## Timing
- Reset values: `busy`=0, `result_valid`=0, `winner`=0, `winner_count`=0, `no_spike`=0; state IDLE.
- Let `start` be sampled high in IDLE at edge E0. Then:
  - COUNT occupies the cycles after E0 through E0+W, where W=`window_cycles`. Spikes are sampled on edges E0+1 … E0+W.
  - SCAN occupies N cycles, where N=`num_neurons`.
  - `result_valid` is high during cycle E0+W+N+1.
- Total latency from `start` to `result_valid` is W+N+1 cycles.
- `busy` is high from cycle E0+1 through E0+W+N and low in DONE.
- Minimum spacing between accepted `start`s is W+N+2 cycles, since `start` is accepted again in the IDLE cycle that follows DONE.
- `start` asserted in the same cycle as reset is ignored.

## Configuration
- Macro `SPIKE_COUNT_SATURATE_EN`.
- Defined: each counter saturates at 2^`count_width`-1. Further spikes leave it unchanged.
- Undefined: counters wrap modulo 2^`count_width`.
- The SCAN comparison is identical in both builds and uses the stored count.

## Test plan
All scenarios use N=4, W=10, `count_width`=4 unless stated.

- **Single active neuron.** `spike_in`=4'b0100 for all 10 COUNT cycles → `winner`=2, `winner_count`=10, `no_spike`=0, `result_valid` exactly 15 cycles after `start`.
- **Tie.** Neurons 1 and 3 each spike on 5 cycles and neuron 0 on 2 → `winner`=1, `winner_count`=5.
- **Silent window.** `spike_in`=0 throughout → `no_spike`=1, `winner`=0, `winner_count`=0, `result_valid` pulses once.
- **Overflow.** `count_width`=3; neuron 0 spikes on all 10 cycles, neuron 1 on 5.
  - With `SPIKE_COUNT_SATURATE_EN`: `winner`=0, `winner_count`=7.
  - Without it: neuron 0 wraps to 2, so `winner`=1, `winner_count`=5.
- **Reset mid-COUNT.** `rst`=0 for one cycle, 5 cycles after `start` → `busy` drops on the next edge, all outputs read 0, no `result_valid`. A new `start` then yields a correct fresh result.
- **Start while busy.** `start` is pulsed during COUNT and during SCAN → ignored. Only one `result_valid` appears, at `start`+15.
